// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state encoding and default parameters for the register file.
package reg_file_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int BYPASS_DEF    = 1;
  localparam int INIT_MODE_DEF = 1;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write port, two read ports and status of the register file.
interface reg_file_if import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();
  logic              WE;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] busW;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic              ready;
  logic              wr_drop;
  modport master (output WE, RW, busW, RA, RB, input busA, busB, ready, wr_drop);
  modport slave  (input WE, RW, busW, RA, RB, output busA, busB, ready, wr_drop);
endinterface

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: asynchronous read port with zero register, ready gating and write forwarding.
module reg_file_rd_port import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = BYPASS_DEF
) (
  input  logic [ADDR_W-1:0] ra_i,
  input  logic              ready_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] rw_i,
  input  logic [DATA_W-1:0] busw_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [DATA_W-1:0] bus_o
);
  always_comb
    bus_o = (!ready_i || ra_i == '0) ? '0 :
            (BYPASS != 0 && we_i && rw_i == ra_i) ? busw_i : mem_i;
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: 2-read/1-write register file with zero entry and self-initialising INIT phase.
module reg_file_param import reg_file_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BYPASS    = BYPASS_DEF,
  parameter int INIT_MODE = INIT_MODE_DEF
) (
  input logic      clk,
  input logic      rst_n,
  reg_file_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  state_t            state_q;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              ready_q, wr_drop_q;
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd, rd_a, rd_b;
  // INIT owns the write port; a reset cycle discards any write
  always_comb begin
    mem_we = rst_n && (state_q == INIT || (bus.WE && bus.RW != '0));
    mem_wa = state_q == INIT ? init_ptr_q : bus.RW;
    mem_wd = state_q == INIT ? (INIT_MODE != 0 ? DATA_W'(init_ptr_q) : '0) : bus.busW;
    rd_a   = bus.RA == '0 ? '0 : mem_q[bus.RA];
    rd_b   = bus.RB == '0 ? '0 : mem_q[bus.RB];
  end
  always_ff @(posedge clk)
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q    <= INIT;
      init_ptr_q <= ADDR_W'(1);
      ready_q    <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      wr_drop_q <= state_q == INIT && bus.WE;
      if (state_q == INIT) begin
        init_ptr_q <= init_ptr_q + ADDR_W'(1);
        if (&init_ptr_q) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      end
    end
  assign bus.ready   = ready_q;
  assign bus.wr_drop = wr_drop_q;
  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_a (
    .ra_i(bus.RA), .ready_i(ready_q), .we_i(bus.WE), .rw_i(bus.RW),
    .busw_i(bus.busW), .mem_i(rd_a), .bus_o(bus.busA));
  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_b (
    .ra_i(bus.RB), .ready_i(ready_q), .we_i(bus.WE), .rw_i(bus.RW),
    .busw_i(bus.busW), .mem_i(rd_b), .bus_o(bus.busB));
endmodule
